// File: rtl/fc_obuf_sched.sv
// fc_obuf_sched -- output-side scheduler for one fully-connected layer.
//
// Walks the layer's output neurons in order. For each neuron it addresses the
// CIM tile output buffers, accumulates the signed partial sums of all vertical
// tiles (one tile per cycle), rescales the sum by an arithmetic right shift,
// saturates it to DATA_SIZE bits and offers it to the next layer over a
// valid/ready handshake.
//
// Optional build macro: FC_OBUF_RELU_EN
//   defined   -> ReLU fused into saturation (negative results become 0)
//   undefined -> plain signed saturation
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         one-cycle pulse: this layer's CIM results are available
//   i_cim_ready     CIM tiles idle, output buffers readable
//   o_busy          scheduler not idle
//   o_cim_rd_addr   neuron index inside the selected horizontal tile
//   o_cim_h_sel     horizontal tile select
//   i_data          V_CIM_TILES signed partial sums, 1-cycle read latency
//   o_valid/o_data  finished neuron value towards the next layer
//   i_next_ready    next layer accepts o_data
//   o_done          one-cycle pulse after the last neuron is accepted
module fc_obuf_sched #(
  parameter int OUTPUT_NEURONS = 10,
  parameter int XBAR_SIZE      = 512,
  parameter int DATA_SIZE      = 8,
  parameter int V_CIM_TILES    = 8,
  parameter int OBUF_DATA_SIZE = 2 * DATA_SIZE + $clog2(XBAR_SIZE),
  parameter int SHIFT          = 4,
  localparam int NPT           = XBAR_SIZE / DATA_SIZE,
  localparam int H_CIM_TILES   = (OUTPUT_NEURONS + NPT - 1) / NPT,
  localparam int ACC_WIDTH     = OBUF_DATA_SIZE + $clog2(V_CIM_TILES) + 1,
  localparam int ADDR_W        = (NPT > 1) ? $clog2(NPT) : 1,
  localparam int HSEL_W        = (H_CIM_TILES > 1) ? $clog2(H_CIM_TILES) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_start,
  input  logic                                  i_cim_ready,
  output logic                                  o_busy,
  output logic [ADDR_W-1:0]                     o_cim_rd_addr,
  output logic [HSEL_W-1:0]                     o_cim_h_sel,
  input  logic [V_CIM_TILES*OBUF_DATA_SIZE-1:0] i_data,
  output logic                                  o_valid,
  input  logic                                  i_next_ready,
  output logic [DATA_SIZE-1:0]                  o_data,
  output logic                                  o_done
);

  localparam int NW = (OUTPUT_NEURONS > 1) ? $clog2(OUTPUT_NEURONS) : 1;
  localparam int VW = (V_CIM_TILES > 1) ? $clog2(V_CIM_TILES) : 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_SIZE - 1)) - 1);
  // Two's complement: ~max == -max-1 == most negative DATA_SIZE value.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic                          pending_q, pending_d;
  logic [NW-1:0]                 n_q, n_d;
  logic [VW-1:0]                 v_q, v_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]             rd_addr_q, rd_addr_d;
  logic [HSEL_W-1:0]             h_sel_q, h_sel_d;
  logic                          valid_q, valid_d;
  logic [DATA_SIZE-1:0]          data_q, data_d;
  logic                          done_q, done_d;

  logic signed [ACC_WIDTH-1:0]   tile_ext [V_CIM_TILES];
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [ACC_WIDTH-1:0]   acc_shr;
  logic [DATA_SIZE-1:0]          sat_val;
  logic                          start_seen;

  // Sign-extend every tile's partial sum to the accumulator width.
  generate
    for (genvar gi = 0; gi < V_CIM_TILES; gi++) begin : g_tile
      assign tile_ext[gi] =
        ACC_WIDTH'(signed'(i_data[gi*OBUF_DATA_SIZE +: OBUF_DATA_SIZE]));
    end
  endgenerate

  // Rescale and saturate the value the accumulator holds after this cycle.
  always_comb begin
    acc_sum = acc_q + tile_ext[v_q];
    acc_shr = acc_sum >>> SHIFT;
    sat_val = acc_shr[DATA_SIZE-1:0];
`ifdef FC_OBUF_RELU_EN
    if (acc_shr[ACC_WIDTH-1]) begin
      sat_val = '0;
    end else if (acc_shr > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_SIZE-1:0];
    end
`else
    if (acc_shr > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_SIZE-1:0];
    end else if (acc_shr < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_SIZE-1:0];
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    n_d        = n_q;
    v_d        = v_q;
    acc_d      = acc_q;
    rd_addr_d  = rd_addr_q;
    h_sel_d    = h_sel_q;
    valid_d    = valid_q;
    data_d     = data_q;
    done_d     = 1'b0;
    start_seen = pending_q | i_start;

    case (state_q)
      S_IDLE: begin
        // A start pulse arriving together with i_cim_ready launches at once.
        if (start_seen && i_cim_ready) begin
          pending_d = 1'b0;
          n_d       = '0;
          rd_addr_d = '0;
          h_sel_d   = '0;
          state_d   = S_ISSUE;
        end else begin
          pending_d = start_seen;
        end
      end
      S_ISSUE: begin
        if (i_cim_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        acc_d   = '0;
        v_d     = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = acc_sum;
        v_d   = v_q + VW'(1);
        if (v_q == VW'(V_CIM_TILES - 1)) begin
          valid_d = 1'b1;
          data_d  = sat_val;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (i_next_ready) begin
          valid_d = 1'b0;
          if (n_q == NW'(OUTPUT_NEURONS - 1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            n_d = n_q + NW'(1);
            // Address counters step alongside n: wrap inside a tile, then
            // move to the next horizontal tile.
            if (rd_addr_q == ADDR_W'(NPT - 1)) begin
              rd_addr_d = '0;
              h_sel_d   = h_sel_q + HSEL_W'(1);
            end else begin
              rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      n_q       <= '0;
      v_q       <= '0;
      acc_q     <= '0;
      rd_addr_q <= '0;
      h_sel_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      n_q       <= n_d;
      v_q       <= v_d;
      acc_q     <= acc_d;
      rd_addr_q <= rd_addr_d;
      h_sel_q   <= h_sel_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_cim_rd_addr = rd_addr_q;
  assign o_cim_h_sel   = h_sel_q;
  assign o_valid       = valid_q;
  assign o_data        = data_q;
  assign o_done        = done_q;

endmodule

// File: doc/fc_obuf_sched.md
Name: fc_obuf_sched

Overview:
Output-side scheduler for one FC layer. It walks the layer's output neurons and, for each one, addresses the CIM tile output buffers. It accumulates the signed partial sums from all vertical CIM tiles one per cycle, then rescales and saturates the result to DATA_SIZE. The finished value streams to the next layer's ibuf over a valid/ready handshake, between the CIM tile array and the next layer's input buffer.

Parameters:
OUTPUT_NEURONS, 10, neurons produced by this layer
XBAR_SIZE, 512, CIM crossbar dimension
DATA_SIZE, 8, weight and output datatype width in bits
V_CIM_TILES, 8, vertical CIM tiles whose partial sums are summed per neuron
OBUF_DATA_SIZE, 2*DATA_SIZE+$clog2(XBAR_SIZE), signed partial-sum width per tile
NPT, XBAR_SIZE/DATA_SIZE, neurons per horizontal tile (derived)
H_CIM_TILES, ceil(OUTPUT_NEURONS/NPT), horizontal tiles (derived)
ACC_WIDTH, OBUF_DATA_SIZE+$clog2(V_CIM_TILES)+1, accumulator width (derived)
SHIFT, 4, arithmetic right shift applied before saturation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse: CIM results of this layer are available
i_cim_ready  in  1  CIM tiles idle and output buffers readable
o_busy  out  1  scheduler active (not IDLE)
o_cim_rd_addr  out  $clog2(NPT)  neuron index within the selected tile
o_cim_h_sel  out  max(1,$clog2(H_CIM_TILES))  horizontal tile select
i_data  in  V_CIM_TILES*OBUF_DATA_SIZE  signed partial sums; tile v at [v*OBUF_DATA_SIZE +: OBUF_DATA_SIZE]; 1-cycle read latency
o_valid  out  1  o_data holds a finished neuron
i_next_ready  in  1  next layer accepts o_data
o_data  out  DATA_SIZE  rescaled, saturated neuron value
o_done  out  1  one-cycle pulse after the last neuron is accepted

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs 0.
  - State=IDLE, neuron counter n=0, tile counter v=0, acc=0, start_pending=0.
  - A reset mid-operation aborts immediately, with no o_done.
- IDLE:
  - i_start sets start_pending.
  - When start_pending && i_cim_ready: clear start_pending, n=0, go to ISSUE.
  - An i_start and i_cim_ready in the same cycle go to ISSUE on the next cycle.
- ISSUE:
  - Drive o_cim_h_sel=n/NPT and o_cim_rd_addr=n%NPT. Both are registered and held until the next ISSUE.
  - If i_cim_ready=0, stall in ISSUE.
  - Otherwise go to WAIT.
- WAIT: one cycle for the buffer read latency; then acc=0, v=0, go to ACC.
- ACC:
  - Each cycle: acc += sign-extended tile v of i_data, v++.
  - After V_CIM_TILES cycles go to EMIT.
  - i_data is sampled only in ACC.
- EMIT:
  - o_valid=1; o_data = sat(acc >>> SHIFT), registered on entry and stable while o_valid=1 and i_next_ready=0.
  - On o_valid && i_next_ready: o_valid=0. If n==OUTPUT_NEURONS-1 go to DONE, else n++ and go to ISSUE.
- DONE: o_done=1 for one cycle, then IDLE.
- o_busy=1 in every state except IDLE.
- Per-neuron latency, ISSUE to first o_valid: V_CIM_TILES+2 cycles. Minimum throughput: one neuron per V_CIM_TILES+3 cycles.
- Edge cases:
  - i_start while busy: ignored, not queued.
  - i_cim_ready falling in WAIT, ACC or EMIT: no effect; only ISSUE checks it.
- Arithmetic:
  - Accumulation is signed, ACC_WIDTH bits, and cannot overflow.
  - The shift is arithmetic (rounds toward -inf).
  - Default saturation: clamp to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].

Optional Feature:
FC_OBUF_RELU_EN
- Defined: ReLU is fused into the saturation stage. Negative shifted values output 0, and positives clamp to 2^(DATA_SIZE-1)-1, so o_data is always >=0.
- Undefined: plain signed saturation as above.
- FSM and timing are identical in both cases.

Test Plan:
1. DATA_SIZE=8, V=4, SHIFT=2, OUTPUT_NEURONS=3, partials {100,200,-50,30} for every neuron, i_next_ready=1 -> three outputs of 70; first o_valid 6 cycles after ISSUE; o_done one cycle after the third accept.
2. Partials {1000,1000,1000,1000} -> o_data=127. Partials {-500,-500,-500,-500} -> -128 without FC_OBUF_RELU_EN, 0 with it. Partials {-100,-100,-100,-100} -> -100 without, 0 with.
3. Backpressure: hold i_next_ready=0 for 5 cycles during EMIT -> o_valid=1 and o_data unchanged for all 5; counter advances only on the accepting cycle.
4. OUTPUT_NEURONS=70, XBAR_SIZE=512 (NPT=64) -> for n=70-1=69: o_cim_h_sel=1, o_cim_rd_addr=5; for n=63: h_sel=0, rd_addr=63.
5. i_start while i_cim_ready=0, then i_cim_ready raised 10 cycles later -> ISSUE one cycle after i_cim_ready rises. Drop i_cim_ready before the second ISSUE -> stall with the address held.
6. Assert rst for one cycle midway through ACC of neuron 1 -> next cycle all outputs 0, o_busy=0, no o_done; a fresh i_start restarts at n=0.
